// File: rtl/static_bus_pkg.sv
// Shared constants and types for the static register bus arbiter and the group decode mux.
package static_bus_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;

    // Read data returned to a requester whose access was aborted by the watchdog
    localparam logic [31:0] ABORT_RDATA = 32'hDEAD_BEEF;

    // Group-ID field inside the static address, decoded by the downstream mux
    localparam int GROUP_ID_MSB = 19;
    localparam int GROUP_ID_LSB = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/static_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above i_ptr, wrapping around.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic [2*N-1:0] w_req_dbl;
    logic [N-1:0]   w_req_rot;
    logic [IDX_W:0] w_off;
    logic [IDX_W:0] w_sum;

    assign w_req_dbl = {i_req, i_req};

    // Bit gi of the rotated vector is requester (i_ptr + gi) mod N
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign w_req_rot[gi] = w_req_dbl[int'(i_ptr) + gi];
    end

    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_off = (IDX_W+1)'(k);
            end
        end
    end

    assign o_valid = |i_req;
    assign w_sum   = {1'b0, i_ptr} + w_off;
    assign o_idx   = (w_sum >= (IDX_W+1)'(N)) ? IDX_W'(w_sum - (IDX_W+1)'(N))
                                              : w_sum[IDX_W-1:0];
    assign o_grant = o_valid ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/static_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing the static register bus among NUM_REQ requesters.
// Optional BUSY watchdog abort enabled by defining STATIC_ARB_TIMEOUT_EN.
module static_bus_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = static_bus_pkg::ADDR_W,
    parameter int DATA_W         = static_bus_pkg::DATA_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_wen,
    input  logic [NUM_REQ-1:0]        req_ren,
    input  logic [NUM_REQ-1:0]        req_scan_id,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      req_err,
    output logic                      static_wen,
    output logic                      static_ren,
    output logic                      static_scan_id,
    output logic [ADDR_W-1:0]         static_addr,
    output logic [DATA_W-1:0]         static_wdata,
    input  logic [DATA_W-1:0]         static_rdata,
    input  logic                      static_ready
);
    import static_bus_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("static_bus_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("static_bus_arbiter: TIMEOUT_CYCLES must fit the 16-bit counter");
    end

    arb_state_e          r_state;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_grant_idx;
    logic [NUM_REQ-1:0]  r_grant_oh;
    logic                r_static_wen;
    logic                r_static_ren;
    logic                r_static_scan_id;
    logic [ADDR_W-1:0]   r_static_addr;
    logic [DATA_W-1:0]   r_static_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [NUM_REQ-1:0]  r_ready;

    logic [NUM_REQ-1:0]  w_req_any;
    logic                w_pick_valid;
    logic [NUM_REQ-1:0]  w_pick_grant;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_sel_wen;
    logic                w_sel_ren;
    logic                w_sel_scan_id;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    assign w_req_any = req_wen | req_ren;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req   (w_req_any),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    assign w_sel_wen     = req_wen[w_pick_idx];
    assign w_sel_ren     = req_ren[w_pick_idx];
    assign w_sel_scan_id = req_scan_id[w_pick_idx];
    assign w_sel_addr    = req_addr[w_pick_idx*ADDR_W +: ADDR_W];
    assign w_sel_wdata   = req_wdata[w_pick_idx*DATA_W +: DATA_W];

`ifdef STATIC_ARB_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic        r_err;
    logic        w_tmo_hit;

    assign w_tmo_hit = (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign req_err   = r_err;
`else
    assign req_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_rr_ptr         <= '0;
            r_grant_idx      <= '0;
            r_grant_oh       <= '0;
            r_static_wen     <= 1'b0;
            r_static_ren     <= 1'b0;
            r_static_scan_id <= 1'b0;
            r_static_addr    <= '0;
            r_static_wdata   <= '0;
            r_rdata          <= '0;
            r_ready          <= '0;
`ifdef STATIC_ARB_TIMEOUT_EN
            r_tmo_cnt        <= '0;
            r_err            <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant_idx      <= w_pick_idx;
                        r_grant_oh       <= w_pick_grant;
                        // A write wins when both strobes are raised together
                        r_static_wen     <= w_sel_wen;
                        r_static_ren     <= w_sel_ren & ~w_sel_wen;
                        r_static_scan_id <= w_sel_scan_id;
                        r_static_addr    <= w_sel_addr;
                        r_static_wdata   <= w_sel_wdata;
`ifdef STATIC_ARB_TIMEOUT_EN
                        r_tmo_cnt        <= '0;
`endif
                        r_state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (static_ready) begin
                        r_static_wen <= 1'b0;
                        r_static_ren <= 1'b0;
                        r_rdata      <= r_static_ren ? static_rdata : '0;
                        r_ready      <= r_grant_oh;
                        r_state      <= RESP;
                    end
`ifdef STATIC_ARB_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_static_wen <= 1'b0;
                        r_static_ren <= 1'b0;
                        r_rdata      <= DATA_W'(ABORT_RDATA);
                        r_err        <= 1'b1;
                        r_ready      <= r_grant_oh;
                        r_state      <= RESP;
                    end else begin
                        r_tmo_cnt    <= r_tmo_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    r_ready  <= '0;
                    r_rdata  <= '0;
`ifdef STATIC_ARB_TIMEOUT_EN
                    r_err    <= 1'b0;
`endif
                    r_rr_ptr <= (r_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                     : r_grant_idx + 1'b1;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_rdata      = r_rdata;
    assign req_ready      = r_ready;
    assign static_wen     = r_static_wen;
    assign static_ren     = r_static_ren;
    assign static_scan_id = r_static_scan_id;
    assign static_addr    = r_static_addr;
    assign static_wdata   = r_static_wdata;

endmodule
